imem_arbiter: RTL and testbench

- Shares the single-port program memory between two requesters: the CPU instruction-fetch port and the program loader (debug/boot path that writes and reads back program bytes).
- Sits between the fetch path/PC logic, the loader, and the memory array.
- Serialises accesses with a round-robin arbiter and a 4-state access sequencer.
- Provides a loader session mode that stalls the CPU while a program is being written.

---
 rtl/imem_arbiter.sv | 110 +++++++++++
 tb/tb_imem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port program memory between CPU fetch
// and the program loader with round-robin grant and a 4-phase sequencer.
module imem_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ldr_ack,
    input  logic                  ldr_session,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        DONE
    } state_t;

    state_t state;
    logic   ptr;
    logic   en_q;
    logic   we_q;
    logic   acc_we;
    logic   cpu_elig;
    logic   ldr_elig;
    logic   grant_ldr;

    assign cpu_elig  = cpu_req & ~ldr_session;
    assign ldr_elig  = ldr_req;
    assign grant_ldr = ldr_elig & (~cpu_elig | ptr);

    // Reset masks the strobes so an abandoned write never lands in the array.
    assign mem_en = en_q & ~rst;
    assign mem_we = we_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            acc_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_elig | ldr_elig) begin
                        state    <= ACCESS;
                        owner    <= grant_ldr;
                        ptr      <= ~grant_ldr;
                        busy     <= 1'b1;
                        en_q     <= 1'b1;
                        we_q     <= grant_ldr & ldr_we;
                        acc_we   <= grant_ldr & ldr_we;
                        mem_addr <= grant_ldr ? ldr_addr : cpu_addr;
                        if (grant_ldr & ldr_we)
                            mem_wdata <= ldr_wdata;
                    end
                end
                ACCESS: begin
                    en_q  <= 1'b0;
                    we_q  <= 1'b0;
                    state <= RESP;
                end
                RESP: begin
                    if (!acc_we) begin
                        if (owner)
                            ldr_rdata <= mem_rdata;
                        else
                            cpu_rdata <= mem_rdata;
                    end
                    ldr_ack <= owner;
                    cpu_ack <= ~owner;
                    state   <= DONE;
                end
                DONE: begin
                    ldr_ack <= 1'b0;
                    cpu_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios, then random traffic
// checked against a transaction-level model of the arbiter.
module tb_imem_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          ldr_req = 1'b0;
    logic          ldr_we = 1'b0;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_ack;
    logic          ldr_session = 1'b0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] ref_mem [16];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    int n_tests = 0;
    int n_fail = 0;

    imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .ldr_session(ldr_session),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory: read data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        tick;
        pre_we = 1'b0;
    endtask

    task automatic do_reset;
        rst         = 1'b1;
        cpu_req     = 1'b0;
        ldr_req     = 1'b0;
        ldr_we      = 1'b0;
        ldr_session = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin : main
        logic [DW-1:0] wd [3];
        int k, t_arb, e_cpu, e_ldr, b_lo, b_hi, g_cyc;
        logic fav, g, ce, le, l_rd, g_own;
        logic [DW-1:0] e_cr, e_lr, p_cr, p_lr;

        rst = 1'b1;
        tick;
        for (int i = 0; i < 16; i++)
            preload(AW'(i), DW'($urandom));
        preload(4'd3, 8'h25);

        // Reset state and a single CPU fetch.
        do_reset;
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ldr_rdata", ldr_rdata, 0);
        chk("rst_owner", owner, 0);
        chk("rst_acks", {cpu_ack, ldr_ack}, 0);
        cpu_req  = 1'b1;
        cpu_addr = 4'd3;
        tick;
        chk("cpu_mem_en", mem_en, 1);
        chk("cpu_mem_addr", mem_addr, 3);
        chk("cpu_mem_we", mem_we, 0);
        chk("cpu_busy", busy, 1);
        tick;
        chk("cpu_ack_early", cpu_ack, 0);
        tick;
        chk("cpu_ack", cpu_ack, 1);
        chk("cpu_rdata", cpu_rdata, 8'h25);
        chk("cpu_ldr_ack", ldr_ack, 0);
        cpu_req = 1'b0;
        tick;
        chk("cpu_busy_end", busy, 0);
        chk("cpu_ack_end", cpu_ack, 0);

        // Loader write then read-back.
        do_reset;
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = 4'd5;
        ldr_wdata = 8'h7A;
        ref_mem[5] = 8'h7A;
        tick;
        chk("lw_mem_we", mem_we, 1);
        chk("lw_mem_en", mem_en, 1);
        chk("lw_mem_addr", mem_addr, 5);
        chk("lw_mem_wdata", mem_wdata, 8'h7A);
        tick;
        chk("lw_mem_we_resp", mem_we, 0);
        tick;
        chk("lw_ack", ldr_ack, 1);
        chk("lw_rdata_hold", ldr_rdata, 0);
        ldr_req = 1'b0;
        tick;
        ldr_req = 1'b1;
        ldr_we  = 1'b0;
        tick;
        chk("lr_mem_we", mem_we, 0);
        chk("lr_mem_en", mem_en, 1);
        tick;
        tick;
        chk("lr_ack", ldr_ack, 1);
        chk("lr_rdata", ldr_rdata, 8'h7A);
        chk("lr_cpu_rdata", cpu_rdata, 0);
        ldr_req = 1'b0;
        tick;

        // Both requesters held: strict alternation starting with CPU.
        do_reset;
        cpu_req  = 1'b1;
        cpu_addr = 4'd1;
        ldr_req  = 1'b1;
        ldr_we   = 1'b0;
        ldr_addr = 4'd6;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rr_owner", owner, i % 2);
            chk("rr_mem_addr", mem_addr, (i % 2) ? 6 : 1);
            chk("rr_acks_a", {cpu_ack, ldr_ack}, 0);
            tick;
            chk("rr_acks_r", {cpu_ack, ldr_ack}, 0);
            tick;
            chk("rr_acks", {cpu_ack, ldr_ack}, (i % 2) ? 2'b01 : 2'b10);
            if (i % 2)
                chk("rr_ldr_rdata", ldr_rdata, ref_mem[6]);
            else
                chk("rr_cpu_rdata", cpu_rdata, ref_mem[1]);
            tick;
            chk("rr_acks_i", {cpu_ack, ldr_ack}, 0);
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        tick;

        // Loader session blocks CPU during three writes.
        do_reset;
        ldr_session = 1'b1;
        cpu_req     = 1'b1;
        cpu_addr    = 4'd7;
        for (int i = 0; i < 3; i++) begin
            ldr_req   = 1'b1;
            ldr_we    = 1'b1;
            ldr_addr  = AW'(8 + i);
            wd[i]     = DW'($urandom);
            ldr_wdata = wd[i];
            ref_mem[8 + i] = wd[i];
            tick;
            chk("ses_owner", owner, 1);
            chk("ses_cpu_ack", cpu_ack, 0);
            tick;
            chk("ses_cpu_ack", cpu_ack, 0);
            tick;
            chk("ses_ldr_ack", ldr_ack, 1);
            chk("ses_cpu_ack", cpu_ack, 0);
            ldr_req = 1'b0;
            tick;
            chk("ses_cpu_ack", cpu_ack, 0);
            chk("ses_busy", busy, 0);
        end
        ldr_session = 1'b0;
        tick;
        chk("ses_cpu_grant", {owner, mem_en}, 2'b01);
        chk("ses_cpu_addr", mem_addr, 7);
        tick;
        tick;
        chk("ses_cpu_ack_end", cpu_ack, 1);
        chk("ses_cpu_rdata", cpu_rdata, ref_mem[7]);
        cpu_req = 1'b0;
        tick;
        for (int i = 0; i < 3; i++)
            chk("ses_mem", mem[8 + i], wd[i]);

        // Reset in the ACCESS cycle of a loader write.
        rst = 1'b1;
        tick;
        preload(4'd2, 8'h11);
        do_reset;
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = 4'd2;
        ldr_wdata = 8'h99;
        tick;
        chk("rw_access", {mem_en, mem_we}, 2'b11);
        rst     = 1'b1;
        ldr_req = 1'b0;
        #1;
        chk("rw_we_masked", mem_we, 0);
        tick;
        chk("rw_outs", {busy, mem_en, mem_we, owner, ldr_ack, cpu_ack}, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rw_no_ack", ldr_ack, 0);
            chk("rw_idle", busy, 0);
        end
        chk("rw_mem", mem[2], 8'h11);

        // Session raised while a CPU access is in RESP.
        do_reset;
        cpu_req  = 1'b1;
        cpu_addr = 4'd4;
        tick;
        tick;
        ldr_session = 1'b1;
        tick;
        chk("sr_cpu_ack", cpu_ack, 1);
        chk("sr_cpu_rdata", cpu_rdata, ref_mem[4]);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("sr_no_grant", {busy, cpu_ack}, 0);
        end
        cpu_req     = 1'b0;
        ldr_session = 1'b0;

        // Random traffic against a transaction-level model.
        do_reset;
        t_arb = 0;
        e_cpu = -1;
        e_ldr = -1;
        b_lo  = 1;
        b_hi  = 0;
        g_cyc = -10;
        g_own = 1'b0;
        fav   = 1'b0;
        l_rd  = 1'b0;
        e_cr  = '0;
        e_lr  = '0;
        p_cr  = '0;
        p_lr  = '0;
        for (k = 0; k < 3000; k++) begin
            if (k == e_cpu) begin
                e_cr = p_cr;
                cpu_req = 1'b0;
            end
            if (k == e_ldr) begin
                if (l_rd)
                    e_lr = p_lr;
                ldr_req = 1'b0;
            end
            chk("rnd_cpu_ack", cpu_ack, k == e_cpu);
            chk("rnd_ldr_ack", ldr_ack, k == e_ldr);
            chk("rnd_busy", busy, (k >= b_lo) && (k <= b_hi));
            chk("rnd_cpu_rdata", cpu_rdata, e_cr);
            chk("rnd_ldr_rdata", ldr_rdata, e_lr);
            if (k == g_cyc + 1)
                chk("rnd_owner", owner, g_own);

            if (!cpu_req && k != e_cpu && $urandom_range(3) == 0) begin
                cpu_req  = 1'b1;
                cpu_addr = AW'($urandom);
            end
            if (!ldr_req && k != e_ldr && $urandom_range(3) == 0) begin
                ldr_req   = 1'b1;
                ldr_we    = 1'($urandom);
                ldr_addr  = AW'($urandom);
                ldr_wdata = DW'($urandom);
            end
            if ($urandom_range(11) == 0)
                ldr_session = ~ldr_session;

            if (k == t_arb) begin
                ce = cpu_req && !ldr_session;
                le = ldr_req;
                if (ce || le) begin
                    g = (ce && le) ? fav : le;
                    fav = ~g;
                    g_cyc = k;
                    g_own = g;
                    b_lo = k + 1;
                    b_hi = k + 3;
                    if (g) begin
                        l_rd = ~ldr_we;
                        if (ldr_we)
                            ref_mem[ldr_addr] = ldr_wdata;
                        else
                            p_lr = ref_mem[ldr_addr];
                        e_ldr = k + 3;
                    end else begin
                        p_cr = ref_mem[cpu_addr];
                        e_cpu = k + 3;
                    end
                    t_arb = k + 4;
                end else begin
                    t_arb = k + 1;
                end
            end
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
